// File: rtl/utm_tape_controller_pkg.sv
// Shared types and constants for the UTM tape-and-head stage.
// Imported by the tape controller and its tape register file.
package utm_tape_controller_pkg;

  localparam int SYM_W   = 3;
  localparam int STATE_W = 3;

  localparam logic MOVE_LEFT  = 1'b0;
  localparam logic MOVE_RIGHT = 1'b1;

  localparam logic [STATE_W-1:0] DEF_HALT_STATE = 3'd7;

  typedef enum logic [1:0] {
    FSM_IDLE = 2'd0,
    FSM_RUN  = 2'd1,
    FSM_HALT = 2'd2
  } fsm_e;

endpackage

// File: rtl/utm_tape_controller_mem.sv
// Tape register file: one write port, two async read ports
// (head and read-back), cleared by the async reset.
module utm_tape_mem
  import utm_tape_controller_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [SYM_W-1:0] wdata,
  input  logic [AW-1:0]    raddr_a,
  output logic [SYM_W-1:0] rdata_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [SYM_W-1:0] rdata_b
);

  logic [SYM_W-1:0] cells [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        cells[i] <= '0;
      end
    end else if (we) begin
      cells[waddr] <= wdata;
    end
  end

  assign rdata_a = cells[raddr_a];
  assign rdata_b = cells[raddr_b];

endmodule

// File: rtl/utm_tape_controller.sv
// Tape, head and state registers of the UTM; commits one
// transition per clock from the combinational transition stage.
module utm_tape_controller
  import utm_tape_controller_pkg::*;
#(
  parameter int                 TAPE_LEN   = 16,
  parameter int                 HEAD_INIT  = 0,
  parameter logic [STATE_W-1:0] HALT_STATE = DEF_HALT_STATE,
  parameter int                 STEP_W     = 8,
  localparam int                AW         = $clog2(TAPE_LEN)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_valid,
  input  logic [SYM_W-1:0]   load_sym,
  input  logic               start,
  output logic [STATE_W-1:0] cur_state,
  output logic [SYM_W-1:0]   cur_sym,
  input  logic [STATE_W-1:0] nxt_state,
  input  logic [SYM_W-1:0]   nxt_sym,
  input  logic               nxt_move,
  output logic               running,
  output logic               halted,
  output logic               timeout,
  output logic [AW-1:0]      head,
  output logic [STEP_W-1:0]  step_count,
  input  logic [AW-1:0]      rd_addr,
  output logic [SYM_W-1:0]   rd_sym
);

  localparam logic [1:0] S_IDLE = FSM_IDLE;
  localparam logic [1:0] S_RUN  = FSM_RUN;
  localparam logic [1:0] S_HALT = FSM_HALT;

  localparam logic [AW-1:0] HEAD_RST = AW'(HEAD_INIT);

  logic [1:0]       fsm;
  logic [AW-1:0]    load_ptr;
  logic             in_idle;
  logic             in_run;
  logic             do_load;
  logic             is_halt;
  logic             last_step;
  logic [AW-1:0]    head_nxt;
  logic [STEP_W-1:0] step_inc;
  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [SYM_W-1:0] mem_wdata;

  assign in_idle   = (fsm == S_IDLE);
  assign in_run    = (fsm == S_RUN);
  assign do_load   = in_idle & load_valid;
  assign is_halt   = (nxt_state == HALT_STATE);
  assign last_step = (step_count == '1);

  // Circular tape: the head simply wraps in its own width.
  assign head_nxt = (nxt_move == MOVE_RIGHT) ?
                    head + AW'(1) : head - AW'(1);

  assign step_inc = last_step ?
                    step_count : step_count + STEP_W'(1);

  assign mem_we    = do_load | in_run;
  assign mem_waddr = in_run ? head : load_ptr;
  assign mem_wdata = in_run ? nxt_sym : load_sym;

  utm_tape_mem #(
    .DEPTH (TAPE_LEN),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (mem_we),
    .waddr   (mem_waddr),
    .wdata   (mem_wdata),
    .raddr_a (head),
    .rdata_a (cur_sym),
    .raddr_b (rd_addr),
    .rdata_b (rd_sym)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm        <= S_IDLE;
      load_ptr   <= '0;
      head       <= '0;
      cur_state  <= '0;
      step_count <= '0;
      timeout    <= 1'b0;
    end else begin
      unique case (fsm)
        S_IDLE: begin
          if (load_valid) begin
            load_ptr <= load_ptr + AW'(1);
          end else if (start) begin
            head       <= HEAD_RST;
            cur_state  <= '0;
            step_count <= '0;
            timeout    <= 1'b0;
            fsm        <= S_RUN;
          end
        end
        S_RUN: begin
          head      <= head_nxt;
          cur_state <= nxt_state;
          // A halting transition wins over the step limit.
          priority case (1'b1)
            is_halt: begin
              step_count <= step_inc;
              fsm        <= S_HALT;
            end
            last_step: begin
              timeout <= 1'b1;
              fsm     <= S_HALT;
            end
            default: begin
              step_count <= step_count + STEP_W'(1);
            end
          endcase
        end
        S_HALT: begin
          if (start) begin
            load_ptr <= '0;
            fsm      <= S_IDLE;
          end
        end
        default: begin
          fsm <= S_IDLE;
        end
      endcase
    end
  end

  assign running = in_run;
  assign halted  = (fsm == S_HALT);

endmodule
